// File: rtl/mem_boot_loader.sv
// Boot sequencer: holds the CPU in reset while a length-prefixed byte stream is
// written into instruction memory then data memory as big-endian byte images.
module mem_boot_loader #(
  parameter int IM_BYTES = 256,
  parameter int DM_BYTES = 256,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [7:0]        im_wdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_LOAD_IM,
    S_LOAD_DM,
    S_RELEASE,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] im_len, dm_len, idx, dm_len_full;
  logic              accept, im_last, dm_last, len_bad;

  assign accept      = in_valid && in_ready;
  // The low dm length byte is still on in_data while HDR3 decides where to go.
  assign dm_len_full = {dm_len[ADDR_W-9:0], in_data};
  assign len_bad     = (32'(im_len) > IM_BYTES) || (32'(dm_len_full) > DM_BYTES);
  assign im_last     = (idx == im_len - ADDR_W'(1));
  assign dm_last     = (idx == dm_len - ADDR_W'(1));

  assign in_ready  = (state == S_HDR0) || (state == S_HDR1) || (state == S_HDR2) ||
                     (state == S_HDR3) || (state == S_LOAD_IM) || (state == S_LOAD_DM);
  assign cpu_reset = (state != S_RUN);
  assign done      = (state == S_RUN);
  assign error     = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_HDR0;
      S_HDR0:    if (accept) state_n = S_HDR1;
      S_HDR1:    if (accept) state_n = S_HDR2;
      S_HDR2:    if (accept) state_n = S_HDR3;
      S_HDR3: begin
        if (accept) begin
          if (len_bad)                  state_n = S_ERR;
          else if (im_len != '0)        state_n = S_LOAD_IM;
          else if (dm_len_full != '0)   state_n = S_LOAD_DM;
          else                          state_n = S_RELEASE;
        end
      end
      S_LOAD_IM: begin
        if (accept && im_last) state_n = (dm_len != '0) ? S_LOAD_DM : S_RELEASE;
      end
      S_LOAD_DM: if (accept && dm_last) state_n = S_RELEASE;
      S_RELEASE: state_n = S_RUN;
      S_RUN:     if (start) state_n = S_HDR0;
      S_ERR:     state_n = S_ERR;
      default:   state_n = S_IDLE;
    endcase
  end

  // Header capture and the registered write ports; addr/data hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_len   <= '0;
      dm_len   <= '0;
      idx      <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else begin
      im_we <= 1'b0;
      dm_we <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR0: im_len <= ADDR_W'(in_data);
          S_HDR1: im_len <= {im_len[ADDR_W-9:0], in_data};
          S_HDR2: dm_len <= ADDR_W'(in_data);
          S_HDR3: begin
            dm_len <= dm_len_full;
            idx    <= '0;
          end
          S_LOAD_IM: begin
            im_we    <= 1'b1;
            im_addr  <= idx;
            im_wdata <= in_data;
            idx      <= im_last ? '0 : idx + ADDR_W'(1);
          end
          S_LOAD_DM: begin
            dm_we    <= 1'b1;
            dm_addr  <= idx;
            dm_wdata <= in_data;
            idx      <= idx + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomised bench for mem_boot_loader: a byte-count reference model predicts
// every output each cycle from the stream format rules.
module tb_mem_boot_loader;

  localparam int IM_BYTES = 256;
  localparam int DM_BYTES = 256;
  localparam int ADDR_W   = 16;

  logic              clk = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, im_we, dm_we, cpu_reset, done, error;
  logic [ADDR_W-1:0] im_addr, dm_addr;
  logic [7:0]        im_wdata, dm_wdata;

  int total = 0;
  int bad   = 0;

  mem_boot_loader #(.IM_BYTES(IM_BYTES), .DM_BYTES(DM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: position in the stream rather than FSM states.
  bit         m_busy, m_rel, m_run, m_err;
  int         m_pos, m_im_len, m_dm_len;
  logic [7:0] m_hdr[4];
  bit         m_im_we, m_dm_we;
  int         m_im_addr, m_dm_addr;
  logic [7:0] m_im_data, m_dm_data;

  task automatic model_update(input logic r, input logic s, input logic v, input logic [7:0] d);
    int k;
    m_im_we = 0;
    m_dm_we = 0;
    if (r) begin
      m_busy = 0; m_rel = 0; m_run = 0; m_err = 0; m_pos = 0;
      m_im_addr = 0; m_dm_addr = 0; m_im_data = 0; m_dm_data = 0;
    end else if (m_rel) begin
      m_rel = 0;
      m_run = 1;
    end else if (m_busy) begin
      if (v) begin
        if (m_pos < 4) begin
          m_hdr[m_pos] = d;
          if (m_pos == 3) begin
            m_im_len = int'(m_hdr[0]) * 256 + int'(m_hdr[1]);
            m_dm_len = int'(m_hdr[2]) * 256 + int'(m_hdr[3]);
            if (m_im_len > IM_BYTES || m_dm_len > DM_BYTES) begin
              m_busy = 0;
              m_err  = 1;
            end else if (m_im_len + m_dm_len == 0) begin
              m_busy = 0;
              m_rel  = 1;
            end
          end
        end else begin
          k = m_pos - 4;
          if (k < m_im_len) begin
            m_im_we = 1; m_im_addr = k; m_im_data = d;
          end else begin
            m_dm_we = 1; m_dm_addr = k - m_im_len; m_dm_data = d;
          end
          if (m_pos + 1 == 4 + m_im_len + m_dm_len) begin
            m_busy = 0;
            m_rel  = 1;
          end
        end
        m_pos++;
      end
    end else if (!m_err && s) begin
      m_busy = 1;
      m_run  = 0;
      m_pos  = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    checkOutput("in_ready",  32'(in_ready),  32'(m_busy));
    checkOutput("cpu_reset", 32'(cpu_reset), 32'(!m_run));
    checkOutput("done",      32'(done),      32'(m_run));
    checkOutput("error",     32'(error),     32'(m_err));
    checkOutput("im_we",     32'(im_we),     32'(m_im_we));
    checkOutput("im_addr",   32'(im_addr),   32'(m_im_addr));
    checkOutput("im_wdata",  32'(im_wdata),  32'(m_im_data));
    checkOutput("dm_we",     32'(dm_we),     32'(m_dm_we));
    checkOutput("dm_addr",   32'(dm_addr),   32'(m_dm_addr));
    checkOutput("dm_wdata",  32'(dm_wdata),  32'(m_dm_data));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [7:0] d);
    reset    = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_update(r, s, v, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random valid plus stray starts.
  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    int  i     = 0;
    int  guard = 0;
    int  limit = 8 * bytes.size() + 64;
    bit  v, s, was_busy;
    while (m_busy && i < bytes.size() && guard < limit) begin
      case (gap)
        0:       v = 1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s        = (gap == 2) && ($urandom_range(0, 7) == 0);
      was_busy = m_busy;
      applyStimulus(1'b0, s, v, v ? bytes[i] : 8'($urandom));
      if (v && was_busy) i++;
      guard++;
    end
    if (guard >= limit) checkOutput("stream_bound", 32'(i), 32'(bytes.size()));
  endtask

  function automatic void make_stream(input int il, input int dl, output logic [7:0] q[$]);
    q = {};
    q.push_back(8'(il >> 8));
    q.push_back(8'(il));
    q.push_back(8'(dl >> 8));
    q.push_back(8'(dl));
    for (int i = 0; i < il + dl; i++) q.push_back(8'($urandom));
  endfunction

  task automatic begin_load();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  logic [7:0] nominal[$];
  logic [7:0] q[$];
  logic [7:0] part[$];

  initial begin
    nominal = {8'h00, 8'h08, 8'h00, 8'h04,
               8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h28, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h01};

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    idle(2);

    begin_load();
    send_stream(nominal, 0);
    idle(3);

    begin_load();
    send_stream(nominal, 1);
    idle(3);

    make_stream(0, 0, q);
    begin_load();
    send_stream(q, 0);
    idle(3);

    q = {8'h01, 8'h01, 8'h00, 8'h00};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    begin_load();
    send_stream(q, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);

    part = nominal[0:6];
    begin_load();
    send_stream(part, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA);
    idle(2);
    begin_load();
    send_stream(nominal, 0);
    idle(3);

    make_stream(4, 0, q);
    begin_load();
    send_stream(q, 0);
    idle(3);

    make_stream(IM_BYTES, 2, q);
    begin_load();
    send_stream(q, 2);
    idle(3);

    for (int t = 0; t < 8; t++) begin
      make_stream($urandom_range(0, 24), $urandom_range(0, 24), q);
      begin_load();
      send_stream(q, 2);
      idle($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
